contador_sequenciador: RTL and testbench

Sequencing controller for the bounded up/down counter datapath. It accepts a configuration: bounds, counting mode and lap count. After `start` it drives the count through the configured pattern, supporting pause/abort and reporting lap and completion events. It sits between a host/control FSM and any consumer of the `saida` count value.

---
 rtl/contador_pkg.sv | 15 +
 rtl/contador_nucleo.sv | 28 ++
 rtl/contador_sequenciador.sv | 133 +++++++++++++
 tb/tb_contador_sequenciador.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// contador_pkg: shared types and constants for the counter sequencer
package contador_pkg;
  typedef enum logic [1:0] {
    MODE_UP_WRAP   = 2'd0,
    MODE_DOWN_WRAP = 2'd1,
    MODE_PING_PONG = 2'd2
  } mode_t;
  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  // Mode code 11 behaves as ping-pong, so only three modes are ever latched
  function automatic mode_t decode_mode(input logic [1:0] m);
    return m == 2'b00 ? MODE_UP_WRAP : m == 2'b01 ? MODE_DOWN_WRAP : MODE_PING_PONG;
  endfunction
endpackage

// File: rtl/contador_nucleo.sv
// contador_nucleo: bounded count register with load/step and bound flags
module contador_nucleo
  import contador_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_step,
  input  logic             i_dir,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_hi,
  output logic [WIDTH-1:0] o_count,
  output logic             o_at_lo,
  output logic             o_at_hi
);
  logic [WIDTH-1:0] r_count;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (i_step) r_count <= i_dir == DIR_DOWN ? r_count - WIDTH'(1) : r_count + WIDTH'(1);
  end
  assign o_count = r_count;
  assign o_at_lo = r_count == i_lo;
  assign o_at_hi = r_count == i_hi;
endmodule

// File: rtl/contador_sequenciador.sv
// contador_sequenciador: config handshake, run FSM and lap tracking around the count core
module contador_sequenciador
  import contador_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int LAPS_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_mode,
  input  logic [WIDTH-1:0]  cfg_lo,
  input  logic [WIDTH-1:0]  cfg_hi,
  input  logic [LAPS_W-1:0] cfg_laps,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  output logic [WIDTH-1:0]  saida,
  output logic              dir,
  output logic              busy,
  output logic              lap_pulse,
  output logic              done
);
  state_t              r_state, w_state_nx;
  mode_t               r_mode, w_cfg_mode;
  logic [WIDTH-1:0]    r_lo, r_hi, w_cfg_lo, w_cfg_hi, w_load_val;
  logic [LAPS_W-1:0]   r_laps, r_lap_cnt, w_lap_nx, w_lap_inc;
  logic                r_dir, w_dir_nx, r_busy, r_lap_pulse, w_lap_pulse_nx, r_done;
  logic                w_xfer, w_abort, w_cfg_take, w_active, w_load, w_step;
  logic                w_at_lo, w_at_hi, w_lap_evt, w_turn, w_fin;

  assign cfg_ready  = r_state == IDLE || r_state == ARMED;
  assign w_xfer     = cfg_valid && cfg_ready;
  assign w_abort    = abort && (r_state == ARMED || r_state == RUN);
  assign w_cfg_take = w_xfer && !w_abort;
  assign w_active   = r_state == RUN && !abort && !pause;
  assign w_cfg_mode = decode_mode(cfg_mode);
  assign w_cfg_lo   = cfg_lo > cfg_hi ? cfg_hi : cfg_lo;
  assign w_cfg_hi   = cfg_lo > cfg_hi ? cfg_lo : cfg_hi;
  // Ping-pong completes a lap only on the low-bound turn; the high turn is a plain hold
  assign w_lap_evt  = r_mode == MODE_UP_WRAP   ? w_at_hi :
                      r_mode == MODE_DOWN_WRAP ? w_at_lo : r_dir == DIR_DOWN && w_at_lo;
  assign w_turn     = r_mode == MODE_PING_PONG && r_dir == DIR_UP && w_at_hi;
  assign w_lap_inc  = r_lap_cnt + LAPS_W'(1);
  assign w_fin      = r_laps != '0 && w_lap_inc == r_laps;

  always_comb begin
    w_state_nx     = r_state;
    w_dir_nx       = r_dir;
    w_lap_nx       = r_lap_cnt;
    w_lap_pulse_nx = 1'b0;
    w_load         = 1'b0;
    w_load_val     = '0;
    w_step         = 1'b0;
    if (w_abort) begin
      w_state_nx = IDLE;
      w_dir_nx   = DIR_UP;
      w_lap_nx   = '0;
      w_load     = 1'b1;
    end else if (w_cfg_take) begin
      w_state_nx = ARMED;
      w_dir_nx   = w_cfg_mode == MODE_DOWN_WRAP ? DIR_DOWN : DIR_UP;
      w_lap_nx   = '0;
      w_load     = 1'b1;
      w_load_val = w_cfg_mode == MODE_DOWN_WRAP ? w_cfg_hi : w_cfg_lo;
    end else if (r_state == ARMED && start) begin
      w_state_nx = RUN;
    end else if (r_state == DONE) begin
      w_state_nx = IDLE;
    end else if (w_active) begin
      if (w_lap_evt) begin
        w_lap_nx       = w_lap_inc;
        w_lap_pulse_nx = 1'b1;
        w_state_nx     = w_fin ? DONE : RUN;
        w_load         = !w_fin && r_mode != MODE_PING_PONG;
        w_load_val     = r_mode == MODE_UP_WRAP ? r_lo : r_hi;
        w_dir_nx       = !w_fin && r_mode == MODE_PING_PONG ? DIR_UP : r_dir;
      end else if (w_turn) begin
        w_dir_nx = DIR_DOWN;
      end else begin
        w_step = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_mode      <= MODE_UP_WRAP;
      r_lo        <= '0;
      r_hi        <= '0;
      r_laps      <= '0;
      r_lap_cnt   <= '0;
      r_dir       <= DIR_UP;
      r_busy      <= 1'b0;
      r_lap_pulse <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_lap_cnt   <= w_lap_nx;
      r_dir       <= w_dir_nx;
      r_busy      <= w_state_nx == RUN;
      r_lap_pulse <= w_lap_pulse_nx;
      r_done      <= w_state_nx == DONE;
      if (w_cfg_take) begin
        r_mode <= w_cfg_mode;
        r_lo   <= w_cfg_lo;
        r_hi   <= w_cfg_hi;
        r_laps <= cfg_laps;
      end
    end
  end

  contador_nucleo #(.WIDTH(WIDTH)) u_nucleo (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_step     (w_step),
    .i_dir      (r_dir),
    .i_lo       (r_lo),
    .i_hi       (r_hi),
    .o_count    (saida),
    .o_at_lo    (w_at_lo),
    .o_at_hi    (w_at_hi)
  );

  assign dir       = r_dir;
  assign busy      = r_busy;
  assign lap_pulse = r_lap_pulse;
  assign done      = r_done;
endmodule

// File: tb/tb_contador_sequenciador.sv
// tb_contador_sequenciador: directed scoreboard bench for the counter sequencer
module tb_contador_sequenciador;
  typedef struct packed {
    logic [3:0] s;
    logic       d;
    logic       b;
    logic       lp;
    logic       dn;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, cfg_valid, cfg_ready, start, pause, abort;
  logic [1:0] cfg_mode;
  logic [3:0] cfg_lo, cfg_hi, saida;
  logic [7:0] cfg_laps;
  logic       dir, busy, lap_pulse, done;
  exp_t       q[$];
  int         n_chk = 0;
  int         n_pass = 0;

  contador_sequenciador #(.WIDTH(4), .LAPS_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mode  (cfg_mode),
    .cfg_lo    (cfg_lo),
    .cfg_hi    (cfg_hi),
    .cfg_laps  (cfg_laps),
    .start     (start),
    .pause     (pause),
    .abort     (abort),
    .saida     (saida),
    .dir       (dir),
    .busy      (busy),
    .lap_pulse (lap_pulse),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] s, input logic d, input logic b, input logic lp, input logic dn);
    q.push_back({s, d, b, lp, dn});
  endtask

  task automatic chk(input string tag);
    exp_t x;
    exp_t o;
    x = q.pop_front();
    o = {saida, dir, busy, lap_pulse, done};
    n_chk++;
    assert (o === x) n_pass++;
    else $error("FAIL %s: {saida,dir,busy,lap,done} got %h want %h", tag, o, x);
  endtask

  task automatic chk1(input string tag, input logic o, input logic x);
    n_chk++;
    assert (o === x) n_pass++;
    else $error("FAIL %s: got %b want %b", tag, o, x);
  endtask

  task automatic run_q(input string tag);
    while (q.size() > 0) begin
      tick();
      chk(tag);
    end
  endtask

  task automatic cfg(input logic [1:0] m, input logic [3:0] lo, input logic [3:0] hi, input logic [7:0] laps);
    cfg_valid = 1'b1;
    cfg_mode  = m;
    cfg_lo    = lo;
    cfg_hi    = hi;
    cfg_laps  = laps;
  endtask

  initial begin
    reset = 1'b0; cfg_valid = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    cfg_mode = '0; cfg_lo = '0; cfg_hi = '0; cfg_laps = '0;
    repeat (2) tick();
    push(4'd0, 0, 0, 0, 0);
    chk("reset");
    chk1("reset_ready", cfg_ready, 1'b1);
    #2 reset = 1'b1;

    // ping-pong 2..5, one lap
    cfg(2'b10, 4'd2, 4'd5, 8'd1);
    push(4'd2, 0, 0, 0, 0);
    run_q("pp_armed");
    cfg_valid = 1'b0;
    start = 1'b1;
    push(4'd2, 0, 1, 0, 0); push(4'd3, 0, 1, 0, 0); push(4'd4, 0, 1, 0, 0);
    push(4'd5, 0, 1, 0, 0); push(4'd5, 1, 1, 0, 0); push(4'd4, 1, 1, 0, 0);
    push(4'd3, 1, 1, 0, 0); push(4'd2, 1, 1, 0, 0); push(4'd2, 1, 0, 1, 1);
    push(4'd2, 1, 0, 0, 0);
    run_q("pp_lap");
    start = 1'b0;
    chk1("pp_idle_ready", cfg_ready, 1'b1);

    // up-wrap 0..3 endless, then abort with pause
    cfg(2'b00, 4'd0, 4'd3, 8'd0);
    push(4'd0, 0, 0, 0, 0);
    run_q("up_armed");
    cfg_valid = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 10; i++) push(4'(i % 4), 0, 1, (i == 4 || i == 8) ? 1'b1 : 1'b0, 0);
    run_q("up_wrap");
    start = 1'b0;
    abort = 1'b1;
    pause = 1'b1;
    push(4'd0, 0, 0, 0, 0);
    run_q("abort_pause");
    abort = 1'b0;
    pause = 1'b0;
    chk1("abort_ready", cfg_ready, 1'b1);

    // down-wrap with swapped bounds, two laps
    cfg(2'b01, 4'd9, 4'd4, 8'd2);
    push(4'd9, 1, 0, 0, 0);
    run_q("dn_armed");
    cfg_valid = 1'b0;
    start = 1'b1;
    for (int i = 9; i >= 4; i--) push(4'(i), 1, 1, 0, 0);
    for (int i = 9; i >= 4; i--) push(4'(i), 1, 1, i == 9 ? 1'b1 : 1'b0, 0);
    push(4'd4, 1, 0, 1, 1);
    push(4'd4, 1, 0, 0, 0);
    run_q("dn_wrap");
    start = 1'b0;

    // lo == hi up-wrap: a lap every cycle
    cfg(2'b00, 4'd5, 4'd5, 8'd3);
    push(4'd5, 0, 0, 0, 0);
    run_q("eq_armed");
    cfg_valid = 1'b0;
    start = 1'b1;
    push(4'd5, 0, 1, 0, 0); push(4'd5, 0, 1, 1, 0); push(4'd5, 0, 1, 1, 0);
    push(4'd5, 0, 0, 1, 1); push(4'd5, 0, 0, 0, 0);
    run_q("eq_laps");
    start = 1'b0;

    // mode 11 ping-pong 0..15 with pause at the high turn
    cfg(2'b11, 4'd0, 4'd15, 8'd0);
    push(4'd0, 0, 0, 0, 0);
    run_q("pp15_armed");
    cfg_valid = 1'b0;
    start = 1'b1;
    for (int i = 0; i <= 15; i++) push(4'(i), 0, 1, 0, 0);
    run_q("pp15_up");
    start = 1'b0;
    pause = 1'b1;
    for (int i = 0; i < 3; i++) push(4'd15, 0, 1, 0, 0);
    run_q("pp15_pause");
    pause = 1'b0;
    push(4'd15, 1, 1, 0, 0);
    for (int i = 14; i >= 7; i--) push(4'(i), 1, 1, 0, 0);
    run_q("pp15_down");

    // asynchronous reset between edges
    #2 reset = 1'b0;
    #1;
    push(4'd0, 0, 0, 0, 0);
    chk("async_reset");
    chk1("async_ready", cfg_ready, 1'b1);
    #1 reset = 1'b1;

    // cfg and start together in ARMED: cfg wins
    cfg(2'b00, 4'd1, 4'd6, 8'd0);
    push(4'd1, 0, 0, 0, 0);
    run_q("re_armed1");
    cfg(2'b01, 4'd2, 4'd8, 8'd0);
    start = 1'b1;
    push(4'd8, 1, 0, 0, 0);
    run_q("re_armed2");
    cfg_valid = 1'b0;
    push(4'd8, 1, 1, 0, 0);
    run_q("re_run");
    start = 1'b0;
    chk1("run_not_ready", cfg_ready, 1'b0);
    cfg(2'b00, 4'd0, 4'd3, 8'd0);
    push(4'd7, 1, 1, 0, 0);
    push(4'd6, 1, 1, 0, 0);
    run_q("cfg_ignored");
    cfg_valid = 1'b0;
    abort = 1'b1;
    push(4'd0, 0, 0, 0, 0);
    run_q("abort_run");
    abort = 1'b0;
    push(4'd0, 0, 0, 0, 0);
    run_q("idle_hold");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
